// File: rtl/mde_pkg.sv
// ---------------------------------------------------------------------------
// mde_pkg
// Shared definitions for the top-of-book order trigger:
//   PRICE_W / QTY_W        widths of price and quantity fields
//   SIDE_BUY / SIDE_SELL   encoding of the order_side output
//   trig_state_e           trigger FSM states
//   tob_snap_t             captured top-of-book snapshot
// ---------------------------------------------------------------------------
package mde_pkg;

  localparam int PRICE_W = 32;
  localparam int QTY_W   = 32;

  localparam logic SIDE_BUY  = 1'b0;
  localparam logic SIDE_SELL = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    EMIT,
    COOLDOWN
  } trig_state_e;

  typedef struct packed {
    logic [PRICE_W-1:0] bid_price;
    logic [QTY_W-1:0]   bid_qty;
    logic [PRICE_W-1:0] ask_price;
    logic [QTY_W-1:0]   ask_qty;
  } tob_snap_t;

endpackage

// File: rtl/token_bucket.sv
// ---------------------------------------------------------------------------
// token_bucket
// Rate limiter for order emission. A free-running refill counter adds one
// token every REFILL_CYCLES cycles (saturating at TOKENS_MAX); each accepted
// consume request removes one token.
// Ports:
//   clk_sys       system clock
//   rst           synchronous active-high reset (bucket full, counter 0)
//   consume       take one token this cycle (ignored when bucket is empty)
//   tokens_avail  current token count
//   token_ok      at least one token available
// ---------------------------------------------------------------------------
module token_bucket #(
  parameter int unsigned TOKENS_MAX    = 4,
  parameter int unsigned REFILL_CYCLES = 1000,
  parameter int unsigned TOK_W         = 3
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             consume,
  output logic [TOK_W-1:0] tokens_avail,
  output logic             token_ok
);

  localparam int RC_W = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(REFILL_CYCLES - 1);
  localparam logic [TOK_W-1:0] TOK_FULL = TOK_W'(TOKENS_MAX);

  logic [RC_W-1:0]  refill_cnt_q, refill_cnt_d;
  logic [TOK_W-1:0] tokens_q, tokens_d;
  logic             refill;
  logic             take;

  assign token_ok     = (tokens_q != '0);
  assign tokens_avail = tokens_q;

  // NOTE: every signal assigned in always_comb gets a default at the top,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    refill       = (refill_cnt_q == RC_LAST);
    refill_cnt_d = refill ? '0 : refill_cnt_q + RC_W'(1);
    take         = consume && token_ok;
    tokens_d     = tokens_q;
    // Refill and consume together cancel out, which also keeps a full
    // bucket full instead of saturating the refill and then dropping one.
    if (refill && !take && (tokens_q < TOK_FULL)) begin
      tokens_d = tokens_q + TOK_W'(1);
    end else if (take && !refill) begin
      tokens_d = tokens_q - TOK_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      refill_cnt_q <= '0;
      tokens_q     <= TOK_FULL;
    end else begin
      refill_cnt_q <= refill_cnt_d;
      tokens_q     <= tokens_d;
    end
  end

endmodule

// File: rtl/tob_order_trigger.sv
// ---------------------------------------------------------------------------
// tob_order_trigger
// Watches top-of-book updates, detects a bid/ask quantity imbalance on a
// tight, uncrossed book and issues one order at a time on a valid/ready
// interface. Orders are rate limited by a token bucket and followed by a
// fixed cooldown. Statistics counters track accepted, dropped and crossed
// events.
// Ports:
//   clk_sys, rst                   clock, synchronous active-high reset
//   arm                            enable for new orders
//   best_bid_price/qty,
//   best_ask_price/qty, tob_valid  top-of-book update (one-cycle pulse)
//   order_valid/ready              order request handshake
//   order_side/price/qty/id        order fields (held while order_valid)
//   trigger_count                  accepted orders
//   drop_count                     qualifying signals that were suppressed
//   crossed_count                  evaluated updates with bid >= ask
//   tokens_avail                   current rate-limiter tokens
// ---------------------------------------------------------------------------
module tob_order_trigger
  import mde_pkg::*;
#(
  parameter int unsigned IMB_SHIFT       = 1,
  parameter int unsigned MAX_SPREAD      = 4,
  parameter int unsigned MAX_ORDER_QTY   = 100,
  parameter int unsigned TOKENS_MAX      = 4,
  parameter int unsigned REFILL_CYCLES   = 1000,
  parameter int unsigned COOLDOWN_CYCLES = 8
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic               arm,
  input  logic [PRICE_W-1:0] best_bid_price,
  input  logic [QTY_W-1:0]   best_bid_qty,
  input  logic [PRICE_W-1:0] best_ask_price,
  input  logic [QTY_W-1:0]   best_ask_qty,
  input  logic               tob_valid,
  output logic               order_valid,
  input  logic               order_ready,
  output logic               order_side,
  output logic [PRICE_W-1:0] order_price,
  output logic [QTY_W-1:0]   order_qty,
  output logic [31:0]        order_id,
  output logic [31:0]        trigger_count,
  output logic [31:0]        drop_count,
  output logic [31:0]        crossed_count,
  output logic [2:0]         tokens_avail
);

  // Imbalance compares are widened so the shifted quantity never truncates.
  localparam int CMP_W = QTY_W + IMB_SHIFT;
  localparam int CD_W  = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [CD_W-1:0]    CD_LAST    = CD_W'(COOLDOWN_CYCLES - 1);
  localparam logic [PRICE_W-1:0] SPREAD_LIM = PRICE_W'(MAX_SPREAD);
  localparam logic [QTY_W-1:0]   QTY_CLAMP  = QTY_W'(MAX_ORDER_QTY);

  trig_state_e state_q, state_d;
  tob_snap_t   snap_q;

  logic               order_valid_q;
  logic               order_side_q;
  logic [PRICE_W-1:0] order_price_q;
  logic [QTY_W-1:0]   order_qty_q;
  logic [31:0]        order_id_q;
  logic [31:0]        trigger_count_q;
  logic [31:0]        drop_count_q;
  logic [31:0]        crossed_count_q;
  logic [CD_W-1:0]    cool_cnt_q, cool_cnt_d;

  // Evaluation of the captured snapshot.
  logic [CMP_W-1:0]   bid_qty_w, ask_qty_w, bid_qty_sh, ask_qty_sh;
  logic [PRICE_W-1:0] spread;
  logic               is_crossed;
  logic               qualified;
  logic               buy_sig, sell_sig, has_signal;
  logic               sig_side;
  logic [PRICE_W-1:0] sig_price;
  logic [QTY_W-1:0]   sig_src_qty, sig_qty;

  // FSM decodes.
  logic capture, fire, drop, crossed_inc, handshake, cool_done;
  logic token_ok;

  always_comb begin
    bid_qty_w   = CMP_W'(snap_q.bid_qty);
    ask_qty_w   = CMP_W'(snap_q.ask_qty);
    bid_qty_sh  = bid_qty_w << IMB_SHIFT;
    ask_qty_sh  = ask_qty_w << IMB_SHIFT;
    is_crossed  = (snap_q.bid_price >= snap_q.ask_price);
    // Only meaningful when the book is not crossed; qualified masks it.
    spread      = snap_q.ask_price - snap_q.bid_price;
    qualified   = !is_crossed && (snap_q.bid_qty != '0) &&
                  (snap_q.ask_qty != '0) && (spread <= SPREAD_LIM);
    buy_sig     = (bid_qty_w > ask_qty_sh);
    sell_sig    = (ask_qty_w > bid_qty_sh);
    has_signal  = qualified && (buy_sig || sell_sig);
    // BUY lifts the offer, SELL hits the bid; size is capped by the
    // quantity resting on the side being taken.
    sig_side    = buy_sig ? SIDE_BUY : SIDE_SELL;
    sig_price   = buy_sig ? snap_q.ask_price : snap_q.bid_price;
    sig_src_qty = buy_sig ? snap_q.ask_qty : snap_q.bid_qty;
    sig_qty     = (sig_src_qty > QTY_CLAMP) ? QTY_CLAMP : sig_src_qty;
  end

  // State register.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (tob_valid) state_d = EVAL;
      EVAL:     state_d = (has_signal && arm && token_ok) ? EMIT : IDLE;
      EMIT:     if (order_ready) state_d = COOLDOWN;
      COOLDOWN: if (cool_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output / control decodes.
  always_comb begin
    capture     = (state_q == IDLE) && tob_valid;
    fire        = (state_q == EVAL) && has_signal && arm && token_ok;
    drop        = (state_q == EVAL) && has_signal && !(arm && token_ok);
    crossed_inc = (state_q == EVAL) && is_crossed;
    handshake   = (state_q == EMIT) && order_valid_q && order_ready;
    cool_done   = (state_q == COOLDOWN) && (cool_cnt_q == CD_LAST);
    cool_cnt_d  = (state_q == COOLDOWN) ? cool_cnt_q + CD_W'(1) : '0;
  end

  // NOTE: the snapshot is pure datapath, always written before EVAL reads
  // it, so it carries no reset; control and visible outputs are reset.
  always_ff @(posedge clk_sys) begin
    if (capture) begin
      snap_q.bid_price <= best_bid_price;
      snap_q.bid_qty   <= best_bid_qty;
      snap_q.ask_price <= best_ask_price;
      snap_q.ask_qty   <= best_ask_qty;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      order_valid_q   <= 1'b0;
      order_side_q    <= SIDE_BUY;
      order_price_q   <= '0;
      order_qty_q     <= '0;
      order_id_q      <= '0;
      trigger_count_q <= '0;
      drop_count_q    <= '0;
      crossed_count_q <= '0;
      cool_cnt_q      <= '0;
    end else begin
      cool_cnt_q <= cool_cnt_d;
      if (fire) begin
        order_valid_q <= 1'b1;
        order_side_q  <= sig_side;
        order_price_q <= sig_price;
        order_qty_q   <= sig_qty;
      end else if (handshake) begin
        order_valid_q <= 1'b0;
      end
      // order_id names the pending order, so it advances only once that
      // order has been accepted downstream.
      if (handshake) begin
        order_id_q      <= order_id_q + 32'd1;
        trigger_count_q <= trigger_count_q + 32'd1;
      end
      if (drop)        drop_count_q    <= drop_count_q + 32'd1;
      if (crossed_inc) crossed_count_q <= crossed_count_q + 32'd1;
    end
  end

  token_bucket #(
    .TOKENS_MAX   (TOKENS_MAX),
    .REFILL_CYCLES(REFILL_CYCLES),
    .TOK_W        (3)
  ) u_token_bucket (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .consume     (fire),
    .tokens_avail(tokens_avail),
    .token_ok    (token_ok)
  );

  assign order_valid   = order_valid_q;
  assign order_side    = order_side_q;
  assign order_price   = order_price_q;
  assign order_qty     = order_qty_q;
  assign order_id      = order_id_q;
  assign trigger_count = trigger_count_q;
  assign drop_count    = drop_count_q;
  assign crossed_count = crossed_count_q;

endmodule

// File: tb/tb_tob_order_trigger.sv
// ---------------------------------------------------------------------------
// tb_tob_order_trigger
// Self-checking bench for tob_order_trigger. Expected orders are pushed to a
// scoreboard queue when a qualifying update is driven and compared by a
// monitor when the DUT completes the handshake.
// ---------------------------------------------------------------------------
module tb_tob_order_trigger;

  localparam int unsigned IMB_SHIFT       = 1;
  localparam int unsigned MAX_SPREAD      = 4;
  localparam int unsigned MAX_ORDER_QTY   = 100;
  localparam int unsigned TOKENS_MAX      = 4;
  localparam int unsigned REFILL_CYCLES   = 1000;
  localparam int unsigned COOLDOWN_CYCLES = 8;
  // Cycles after a send until a new update can be captured again when the
  // order is accepted immediately (eval, emit, handshake, cooldown).
  localparam int SETTLE = 2 + COOLDOWN_CYCLES;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic [31:0] best_bid_price = '0, best_bid_qty = '0;
  logic [31:0] best_ask_price = '0, best_ask_qty = '0;
  logic        tob_valid = 1'b0;
  logic        order_valid;
  logic        order_ready = 1'b0;
  logic        order_side;
  logic [31:0] order_price, order_qty, order_id;
  logic [31:0] trigger_count, drop_count, crossed_count;
  logic [2:0]  tokens_avail;

  always #5 clk_sys = ~clk_sys;

  tob_order_trigger #(
    .IMB_SHIFT      (IMB_SHIFT),
    .MAX_SPREAD     (MAX_SPREAD),
    .MAX_ORDER_QTY  (MAX_ORDER_QTY),
    .TOKENS_MAX     (TOKENS_MAX),
    .REFILL_CYCLES  (REFILL_CYCLES),
    .COOLDOWN_CYCLES(COOLDOWN_CYCLES)
  ) dut (
    .clk_sys       (clk_sys),
    .rst           (rst),
    .arm           (arm),
    .best_bid_price(best_bid_price),
    .best_bid_qty  (best_bid_qty),
    .best_ask_price(best_ask_price),
    .best_ask_qty  (best_ask_qty),
    .tob_valid     (tob_valid),
    .order_valid   (order_valid),
    .order_ready   (order_ready),
    .order_side    (order_side),
    .order_price   (order_price),
    .order_qty     (order_qty),
    .order_id      (order_id),
    .trigger_count (trigger_count),
    .drop_count    (drop_count),
    .crossed_count (crossed_count),
    .tokens_avail  (tokens_avail)
  );

  typedef struct {
    logic        side;
    logic [31:0] price;
    logic [31:0] qty;
    logic [31:0] id;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] exp_id;
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;

  // Edges since reset was released.
  always @(posedge clk_sys) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // A handshake completes at the next rising edge; check it mid-cycle.
  always @(negedge clk_sys) begin
    if (!rst && order_valid && order_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_order side=%0d price=%0d qty=%0d id=%0d",
                 order_side, order_price, order_qty, order_id);
      end else begin
        mon_e = sb_q.pop_front();
        if (order_side !== mon_e.side || order_price !== mon_e.price ||
            order_qty !== mon_e.qty || order_id !== mon_e.id) begin
          failures++;
          $display("FAIL sb_order got side=%0d price=%0d qty=%0d id=%0d exp side=%0d price=%0d qty=%0d id=%0d",
                   order_side, order_price, order_qty, order_id,
                   mon_e.side, mon_e.price, mon_e.qty, mon_e.id);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reference decision for one book update (arithmetic widened to 64 bits).
  function automatic bit model(input logic [31:0] bp, bq, ap, aq,
                               output logic side, output logic [31:0] price,
                               output logic [31:0] qty);
    longint unsigned lbq = 64'(bq);
    longint unsigned laq = 64'(aq);
    longint unsigned k   = 64'(1) << IMB_SHIFT;
    side = 1'b0; price = '0; qty = '0;
    if (bp >= ap) return 1'b0;
    if (bq == 0 || aq == 0 || (ap - bp) > MAX_SPREAD) return 1'b0;
    if (lbq > laq * k) begin
      side = 1'b0; price = ap; qty = (aq > MAX_ORDER_QTY) ? MAX_ORDER_QTY : aq;
      return 1'b1;
    end
    if (laq > lbq * k) begin
      side = 1'b1; price = bp; qty = (bq > MAX_ORDER_QTY) ? MAX_ORDER_QTY : bq;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Drive one tob_valid pulse. expect_accept: the bench knows the FSM is
  // idle, armed and has a token, so a signal must become an order.
  task automatic send_tob(input logic [31:0] bp, bq, ap, aq, input bit expect_accept);
    exp_t e;
    logic s;
    logic [31:0] p, q;
    best_bid_price = bp; best_bid_qty = bq;
    best_ask_price = ap; best_ask_qty = aq;
    tob_valid = 1'b1;
    if (model(bp, bq, ap, aq, s, p, q) && expect_accept) begin
      e.side = s; e.price = p; e.qty = q; e.id = exp_id;
      sb_q.push_back(e);
      exp_id++;
    end
    tick();
    tob_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; arm = 1'b0; order_ready = 1'b0; tob_valid = 1'b0;
    ticks(2);
    rst = 1'b0;
    sb_q.delete();
    exp_id = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (order_valid !== 1'b0 || order_side !== 1'b0 || order_price !== 32'd0 ||
        order_qty !== 32'd0 || order_id !== 32'd0) begin
      failures++;
      $display("FAIL reset_order got v=%0d s=%0d p=%0d q=%0d id=%0d exp all 0",
               order_valid, order_side, order_price, order_qty, order_id);
    end
    checks++;
    if ({trigger_count, drop_count, crossed_count} !== 96'd0) begin
      failures++;
      $display("FAIL reset_counters got trig=%0d drop=%0d crossed=%0d exp 0",
               trigger_count, drop_count, crossed_count);
    end
    checks++;
    if (tokens_avail !== 3'(TOKENS_MAX)) begin
      failures++;
      $display("FAIL reset_tokens got=%0d exp=%0d", tokens_avail, TOKENS_MAX);
    end
  endtask

  task automatic test_buy();
    do_reset();
    arm = 1'b1; order_ready = 1'b1;
    send_tob(32'd1000, 32'd500, 32'd1002, 32'd200, 1'b1);
    checks++;
    if (order_valid !== 1'b0) begin
      failures++;
      $display("FAIL buy_latency_n1 got valid=%0d exp=0", order_valid);
    end
    tick();
    checks++;
    if (order_valid !== 1'b1 || order_side !== 1'b0 || order_price !== 32'd1002 ||
        order_qty !== 32'd100 || order_id !== 32'd0) begin
      failures++;
      $display("FAIL buy_order_n2 got v=%0d s=%0d p=%0d q=%0d id=%0d exp v=1 s=0 p=1002 q=100 id=0",
               order_valid, order_side, order_price, order_qty, order_id);
    end
    tick();
    checks++;
    if (order_valid !== 1'b0 || trigger_count !== 32'd1 || tokens_avail !== 3'd3 ||
        order_id !== 32'd1) begin
      failures++;
      $display("FAIL buy_after_hs got v=%0d trig=%0d tok=%0d id=%0d exp v=0 trig=1 tok=3 id=1",
               order_valid, trigger_count, tokens_avail, order_id);
    end
    ticks(SETTLE - 1);
  endtask

  task automatic test_sell();
    do_reset();
    arm = 1'b1; order_ready = 1'b1;
    send_tob(32'd1000, 32'd50, 32'd1001, 32'd300, 1'b1);
    tick();
    checks++;
    if (order_valid !== 1'b1 || order_side !== 1'b1 || order_price !== 32'd1000 ||
        order_qty !== 32'd50) begin
      failures++;
      $display("FAIL sell_order got v=%0d s=%0d p=%0d q=%0d exp v=1 s=1 p=1000 q=50",
               order_valid, order_side, order_price, order_qty);
    end
    ticks(SETTLE);
  endtask

  task automatic test_crossed_and_wide();
    do_reset();
    arm = 1'b1; order_ready = 1'b1;
    send_tob(32'd1005, 32'd500, 32'd1003, 32'd100, 1'b1);
    ticks(4);
    checks++;
    if (crossed_count !== 32'd1 || trigger_count !== 32'd0 || drop_count !== 32'd0 ||
        tokens_avail !== 3'd4) begin
      failures++;
      $display("FAIL crossed got crossed=%0d trig=%0d drop=%0d tok=%0d exp 1 0 0 4",
               crossed_count, trigger_count, drop_count, tokens_avail);
    end
    do_reset();
    arm = 1'b1; order_ready = 1'b1;
    send_tob(32'd1000, 32'd500, 32'd1010, 32'd100, 1'b1);
    ticks(4);
    checks++;
    if ({trigger_count, drop_count, crossed_count} !== 96'd0 || tokens_avail !== 3'd4) begin
      failures++;
      $display("FAIL wide_spread got trig=%0d drop=%0d crossed=%0d tok=%0d exp 0 0 0 4",
               trigger_count, drop_count, crossed_count, tokens_avail);
    end
  endtask

  // Spread at the limit, quantity below the clamp, exact-ratio imbalance,
  // a shifted compare beyond 32 bits, and a disarmed signal.
  task automatic test_qualify();
    do_reset();
    arm = 1'b1; order_ready = 1'b1;
    send_tob(32'd1000, 32'd300, 32'd1004, 32'd37, 1'b1);
    tick();
    checks++;
    if (order_valid !== 1'b1 || order_price !== 32'd1004 || order_qty !== 32'd37) begin
      failures++;
      $display("FAIL qual_spread_edge got v=%0d p=%0d q=%0d exp v=1 p=1004 q=37",
               order_valid, order_price, order_qty);
    end
    ticks(SETTLE - 1);
    send_tob(32'd1000, 32'd200, 32'd1001, 32'd100, 1'b1);
    ticks(3);
    send_tob(32'd1000, 32'h8000_0000, 32'd1001, 32'hFFFF_FFFF, 1'b1);
    ticks(3);
    arm = 1'b0;
    send_tob(32'd1000, 32'd500, 32'd1002, 32'd200, 1'b0);
    ticks(3);
    arm = 1'b1;
    checks++;
    if (trigger_count !== 32'd1 || drop_count !== 32'd1 || crossed_count !== 32'd0 ||
        tokens_avail !== 3'd3) begin
      failures++;
      $display("FAIL qual_counters got trig=%0d drop=%0d crossed=%0d tok=%0d exp 1 1 0 3",
               trigger_count, drop_count, crossed_count, tokens_avail);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    arm = 1'b1; order_ready = 1'b0;
    send_tob(32'd1000, 32'd500, 32'd1002, 32'd200, 1'b1);
    tick();
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 0) send_tob(32'd1000, 32'd50, 32'd1001, 32'd300, 1'b0);
      else            tick();
      checks++;
      if ({order_valid, order_side, order_price, order_qty, order_id} !==
          {1'b1, 1'b0, 32'd1002, 32'd100, 32'd0}) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got v=%0d s=%0d p=%0d q=%0d id=%0d exp v=1 s=0 p=1002 q=100 id=0",
                 i, order_valid, order_side, order_price, order_qty, order_id);
      end
    end
    checks++;
    if (drop_count !== 32'd0 || tokens_avail !== 3'd3) begin
      failures++;
      $display("FAIL bp_ignored got drop=%0d tok=%0d exp drop=0 tok=3", drop_count, tokens_avail);
    end
    order_ready = 1'b1;
    tick();
    checks++;
    if (order_valid !== 1'b0 || trigger_count !== 32'd1) begin
      failures++;
      $display("FAIL bp_handshake got v=%0d trig=%0d exp v=0 trig=1", order_valid, trigger_count);
    end
    // Last cooldown edge: must be ignored. The next edge is back in IDLE.
    ticks(COOLDOWN_CYCLES - 1);
    send_tob(32'd1000, 32'd50, 32'd1001, 32'd300, 1'b0);
    send_tob(32'd1000, 32'd500, 32'd1002, 32'd200, 1'b1);
    tick();
    checks++;
    if (order_valid !== 1'b1 || order_side !== 1'b0 || order_id !== 32'd1) begin
      failures++;
      $display("FAIL cooldown_len got v=%0d s=%0d id=%0d exp v=1 s=0 id=1",
               order_valid, order_side, order_id);
    end
    ticks(SETTLE);
    checks++;
    if (trigger_count !== 32'd2 || drop_count !== 32'd0) begin
      failures++;
      $display("FAIL bp_final got trig=%0d drop=%0d exp trig=2 drop=0", trigger_count, drop_count);
    end
  endtask

  task automatic test_reset_mid_order();
    do_reset();
    arm = 1'b1; order_ready = 1'b0;
    send_tob(32'd1000, 32'd500, 32'd1002, 32'd200, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (order_valid !== 1'b0 || trigger_count !== 32'd0 || tokens_avail !== 3'd4) begin
      failures++;
      $display("FAIL reset_mid got v=%0d trig=%0d tok=%0d exp v=0 trig=0 tok=4",
               order_valid, trigger_count, tokens_avail);
    end
    do_reset();
  endtask

  task automatic test_tokens();
    int guard;
    do_reset();
    arm = 1'b1; order_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send_tob(32'd1000, 32'd500, 32'd1002, 32'd200, k < 4);
      ticks(SETTLE);
    end
    checks++;
    if (trigger_count !== 32'd4 || drop_count !== 32'd1 || tokens_avail !== 3'd0 ||
        order_id !== 32'd4) begin
      failures++;
      $display("FAIL tok_exhaust got trig=%0d drop=%0d tok=%0d id=%0d exp 4 1 0 4",
               trigger_count, drop_count, tokens_avail, order_id);
    end
    guard = 0;
    while (cyc < REFILL_CYCLES - 1 && guard < 2 * REFILL_CYCLES) begin
      tick();
      guard++;
    end
    checks++;
    if (cyc != REFILL_CYCLES - 1 || tokens_avail !== 3'd0) begin
      failures++;
      $display("FAIL tok_pre_refill got cyc=%0d tok=%0d exp cyc=%0d tok=0",
               cyc, tokens_avail, REFILL_CYCLES - 1);
    end
    tick();
    checks++;
    if (tokens_avail !== 3'd1) begin
      failures++;
      $display("FAIL tok_refill got=%0d exp=1", tokens_avail);
    end
    send_tob(32'd1000, 32'd500, 32'd1002, 32'd200, 1'b1);
    tick();
    checks++;
    if (order_valid !== 1'b1 || order_id !== 32'd4) begin
      failures++;
      $display("FAIL tok_next_order got v=%0d id=%0d exp v=1 id=4", order_valid, order_id);
    end
    tick();
    checks++;
    if (trigger_count !== 32'd5 || tokens_avail !== 3'd0) begin
      failures++;
      $display("FAIL tok_final got trig=%0d tok=%0d exp trig=5 tok=0", trigger_count, tokens_avail);
    end
    ticks(SETTLE - 1);
  endtask

  initial begin
    exp_id = '0;
    test_reset();
    test_buy();
    test_sell();
    test_crossed_and_wide();
    test_qualify();
    test_backpressure();
    test_reset_mid_order();
    test_tokens();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
